// File: rtl/uart_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_pkg: receiver FSM state encoding and baud sizing helpers. Rev 1.0
// ---------------------------------------------------------------------------
package uart_pkg;

  localparam int CLKS_PER_BIT_MIN = 4;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_HIGH = 3'd5
  } uart_state_e;

  function automatic int calc_clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

  function automatic int calc_cnt_width(input int clks_per_bit);
    return (clks_per_bit > 1) ? $clog2(clks_per_bit) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sync_2ff: two-flop synchroniser with parameterised reset value. Rev 1.0
// ---------------------------------------------------------------------------
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule
`default_nettype wire

// File: rtl/uart_rx_byte_latch.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_rx_byte_latch: 8N1 receiver holding the last good byte; define
// UART_RX_PARITY_EN for 8E1 framing with a parity_error pulse. Rev 1.0
// ---------------------------------------------------------------------------
module uart_rx_byte_latch
  import uart_pkg::*;
#(
  parameter int sys_clk_freq = 100000000,
  parameter int baud_rate    = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] hex_byte,
  output logic       byte_valid,
  output logic       framing_error
`ifdef UART_RX_PARITY_EN
  ,
  output logic       parity_error
`endif
);

  localparam int CLKS_PER_BIT = calc_clks_per_bit(sys_clk_freq, baud_rate);
  localparam int CNT_W        = calc_cnt_width(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

  generate
    if (CLKS_PER_BIT < CLKS_PER_BIT_MIN) begin : g_cpb_check
      $error("uart_rx_byte_latch: clks_per_bit below minimum of 4");
    end
  endgenerate

  logic             rx_s;
  uart_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       hex_q, hex_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
  logic             par_q, par_d;
  logic             perr_q, perr_d;
`endif

  sync_2ff #(.RESET_VAL(1'b1)) u_rx_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (rx),
    .q_o   (rx_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      hex_q     <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q     <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      hex_q     <= hex_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
`ifdef UART_RX_PARITY_EN
      par_q     <= par_d;
      perr_q    <= perr_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    hex_d     = hex_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d     = par_q;
    perr_d    = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = ST_START;
      end
      ST_START: begin
        // Mid start bit: a high level here means the falling edge was a glitch.
        if (cnt_q == CNT_HALF) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = rx_s ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (cnt_q == CNT_LAST) begin
          shift_d   = {rx_s, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (cnt_q == CNT_LAST) begin
          par_d   = rx_s;
          state_d = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        // Leaving mid stop bit lets a 1-bit stop feed straight into the next start.
        if (cnt_q == CNT_LAST) begin
          if (!rx_s) begin
            ferr_d  = 1'b1;
            state_d = ST_WAIT_HIGH;
          end else begin
            state_d = ST_IDLE;
`ifdef UART_RX_PARITY_EN
            if ((^shift_q) ^ par_q) begin
              perr_d = 1'b1;
            end else begin
              valid_d = 1'b1;
              hex_d   = shift_q;
            end
`else
            valid_d = 1'b1;
            hex_d   = shift_q;
`endif
          end
        end
      end
      ST_WAIT_HIGH: begin
        cnt_d = '0;
        if (rx_s) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign hex_byte      = hex_q;
  assign byte_valid    = valid_q;
  assign framing_error = ferr_q;
`ifdef UART_RX_PARITY_EN
  assign parity_error  = perr_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_byte_latch.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_uart_rx_byte_latch: directed and random 8N1 frames against a frame-level
// expectation queue. Rev 1.0
// ---------------------------------------------------------------------------
module tb_uart_rx_byte_latch;

  localparam int CPB     = 100;
  localparam int LAT_NOM = 953;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx    = 1'b1;
  logic [7:0] hex_byte;
  logic       byte_valid;
  logic       framing_error;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
    int         start;
  } ev_t;

  ev_t        exp_q[$];
  logic [7:0] exp_hex = 8'h00;
  int         cyc     = 0;
  int         n_chk   = 0;
  int         n_pass  = 0;

  uart_rx_byte_latch #(
    .sys_clk_freq (100000000),
    .baud_rate    (1000000)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rx            (rx),
    .hex_byte      (hex_byte),
    .byte_valid    (byte_valid),
    .framing_error (framing_error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
  endtask

  // Every output pulse must match the next frame the driver queued.
  always @(negedge clk) begin : monitor
    ev_t e;
    int  lat;
    if (byte_valid || framing_error) begin
      chk("exclusive", {31'd0, byte_valid & framing_error}, 32'd0);
      if (exp_q.size() == 0) begin
        chk("spurious_pulse", {30'd0, byte_valid, framing_error}, 32'd0);
      end else begin
        e   = exp_q.pop_front();
        lat = cyc - e.start;
        chk("pulse_kind", {31'd0, framing_error}, {31'd0, e.is_err});
        chk("latency", (lat >= LAT_NOM - 2 && lat <= LAT_NOM + 2) ? LAT_NOM : lat, LAT_NOM);
        if (!e.is_err) begin
          chk("byte_data", {24'd0, hex_byte}, {24'd0, e.data});
          exp_hex = e.data;
        end else begin
          chk("hex_kept_on_ferr", {24'd0, hex_byte}, {24'd0, exp_hex});
        end
      end
    end else begin
      chk("hex_hold", {24'd0, hex_byte}, {24'd0, exp_hex});
    end
  end

  task automatic bit_time(input logic v);
    rx = v;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit stop_ok, input int low_bits);
    ev_t e;
    e.is_err = !stop_ok;
    e.data   = d;
    e.start  = cyc;
    exp_q.push_back(e);
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(d[i]);
    if (stop_ok) bit_time(1'b1);
    else for (int i = 0; i < 1 + low_bits; i++) bit_time(1'b0);
  endtask

  initial begin : stim
    logic [7:0] ab;
    logic [7:0] d;
    bit         bad;
    int         gap;

    rst_n = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1 rx = 1'($urandom_range(0, 1));
    end
    chk("rst_hex",   {24'd0, hex_byte}, 32'h00);
    chk("rst_valid", {31'd0, byte_valid}, 32'd0);
    chk("rst_ferr",  {31'd0, framing_error}, 32'd0);
    rx = 1'b1;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    send_frame(8'hA5, 1'b1, 0);
    bit_time(1'b1);
    bit_time(1'b1);
    chk("a5_held", {24'd0, hex_byte}, 32'hA5);

    send_frame(8'h3C, 1'b1, 0);
    send_frame(8'hFF, 1'b1, 0);
    send_frame(8'h00, 1'b1, 0);
    bit_time(1'b1);
    chk("b2b_last", {24'd0, hex_byte}, 32'h00);

    rx = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    bit_time(1'b1);
    bit_time(1'b1);
    send_frame(8'h12, 1'b1, 0);
    bit_time(1'b1);
    chk("after_glitch", {24'd0, hex_byte}, 32'h12);

    send_frame(8'h7E, 1'b0, 3);
    bit_time(1'b1);
    chk("ferr_hex_kept", {24'd0, hex_byte}, 32'h12);
    send_frame(8'h81, 1'b1, 0);
    bit_time(1'b1);
    chk("after_ferr", {24'd0, hex_byte}, 32'h81);

    // Abort 0x55 during bit 4 with an asynchronous reset.
    ab = 8'h55;
    bit_time(1'b0);
    for (int i = 0; i < 4; i++) bit_time(ab[i]);
    rx = ab[4];
    repeat (37) @(posedge clk);
    #2 rst_n = 1'b0;
    exp_hex = 8'h00;
    #1;
    chk("async_rst_hex",   {24'd0, hex_byte}, 32'h00);
    chk("async_rst_valid", {31'd0, byte_valid}, 32'd0);
    chk("async_rst_ferr",  {31'd0, framing_error}, 32'd0);
    rx = 1'b1;
    repeat (20) @(posedge clk);
    #1 rst_n = 1'b1;
    bit_time(1'b1);
    send_frame(8'h99, 1'b1, 0);
    bit_time(1'b1);
    chk("after_reset", {24'd0, hex_byte}, 32'h99);

    for (int n = 0; n < 12; n++) begin
      d   = 8'($urandom);
      bad = ($urandom_range(0, 4) == 0);
      send_frame(d, !bad, bad ? int'($urandom_range(1, 3)) : 0);
      gap = bad ? 1 + int'($urandom_range(0, 2)) : int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) bit_time(1'b1);
    end
    bit_time(1'b1);

    for (int i = 0; i < 3000 && exp_q.size() != 0; i++) @(posedge clk);
    chk("drain", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
